// File: rtl/line_window_gen.sv
// line_window_gen
//   Streaming KxK sliding-window generator. Buffers K-1 full rows in
//   circular line RAMs and, for every accepted pixel once K rows and K
//   columns are present, emits the full KxK neighbourhood in one word.
//
// Ports
//   i_clk        clock
//   i_rstn       synchronous active-low reset
//   i_sof        start of frame, qualifies the pixel on i_data (with i_valid)
//   i_valid      pixel strobe
//   i_data       pixel
//   o_valid      1-cycle strobe: o_window holds a complete window
//   o_window     window, element (r,c) at [(r*K+c)*DW +: DW], r=0 oldest row
//   o_row/o_col  frame coordinates of the window centre
//   o_frame_done 1-cycle pulse after the last pixel of a frame is accepted
module line_window_gen #(
  parameter int unsigned DW    = 12,
  parameter int unsigned RL    = 640,
  parameter int unsigned NROWS = 480,
  parameter int unsigned K     = 3
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_sof,
  input  logic              i_valid,
  input  logic [DW-1:0]     i_data,
  output logic              o_valid,
  output logic [K*K*DW-1:0] o_window,
  output logic [15:0]       o_row,
  output logic [15:0]       o_col,
  output logic              o_frame_done
);

  localparam int unsigned CW   = (RL > 1) ? $clog2(RL) : 1;
  localparam int unsigned RW   = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int unsigned NL   = K - 1;
  localparam int unsigned PW   = (NL > 1) ? $clog2(NL) : 1;
  localparam int unsigned HALF = (K - 1) / 2;

  localparam logic [CW-1:0] COL_LAST = CW'(RL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NROWS - 1);
  localparam logic [CW-1:0] KM1_C    = CW'(K - 1);
  localparam logic [RW-1:0] KM1_R    = RW'(K - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NL - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t          state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [PW-1:0]   wptr_q;

  logic [DW-1:0]   lram [NL][RL];

  // Only K-1 history columns per row are stored; the K-th (rightmost) tap
  // is the live column formed from i_data and the line RAM read ports.
  logic [DW-1:0]   hist_q [K][K-1];
  logic [DW-1:0]   hist_d [K][K-1];
  logic [DW-1:0]   newcol [K];
  logic [K*K*DW-1:0] win_flat;

  logic            accept;
  logic [CW-1:0]   pc;
  logic [RW-1:0]   pr;
  logic [PW-1:0]   pw;
  logic            col_end;
  logic            last_px;
  logic            win_ok;
  logic [CW-1:0]   col_nx;
  logic [RW-1:0]   row_nx;
  logic [PW-1:0]   wptr_nx;
  int unsigned     ri;

  // An i_sof pixel is always (0,0) with the row pointer rewound, whether it
  // starts a frame from IDLE or resyncs mid-frame.
  always_comb begin
    accept  = i_valid && ((state_q != IDLE) || i_sof);
    pc      = i_sof ? '0 : col_q;
    pr      = i_sof ? '0 : row_q;
    pw      = i_sof ? '0 : wptr_q;
    col_end = (pc == COL_LAST);
    last_px = col_end && (pr == ROW_LAST);
    win_ok  = (pr >= KM1_R) && (pc >= KM1_C);
    col_nx  = col_end ? '0 : pc + 1'b1;
    row_nx  = col_end ? pr + 1'b1 : pr;
    wptr_nx = col_end ? ((pw == PTR_LAST) ? '0 : pw + 1'b1) : pw;
  end

  // RAM (pw + r) mod (K-1) holds the row K-1-r rows above the current one,
  // because the pointer advances by one RAM per row.
  always_comb begin
    ri       = 0;
    win_flat = '0;
    for (int unsigned r = 0; r < K; r++) begin
      newcol[r] = '0;
      for (int unsigned c = 0; c < K - 1; c++) hist_d[r][c] = '0;
    end
    for (int unsigned r = 0; r < K; r++) begin
      if (r == K - 1) begin
        newcol[r] = i_data;
      end else begin
        ri        = (32'(pw) + r) % NL;
        newcol[r] = lram[ri[PW-1:0]][pc];
      end
    end
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        if (c < K - 1) win_flat[(r*K+c)*DW +: DW] = hist_q[r][c];
        else           win_flat[(r*K+c)*DW +: DW] = newcol[r];
      end
      for (int unsigned c = 0; c < K - 1; c++) begin
        if (c < K - 2) hist_d[r][c] = hist_q[r][c+1];
        else           hist_d[r][c] = newcol[r];
      end
    end
  end

  // Line RAMs: read (combinational, above) happens before this write.
  always_ff @(posedge i_clk) begin
    if (i_rstn && accept) lram[pw][pc] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      wptr_q       <= '0;
      o_valid      <= 1'b0;
      o_window     <= '0;
      o_row        <= '0;
      o_col        <= '0;
      o_frame_done <= 1'b0;
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K - 1; c++)
          hist_q[r][c] <= '0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      if (accept) begin
        hist_q <= hist_d;
        if (last_px) begin
          state_q      <= IDLE;
          col_q        <= '0;
          row_q        <= '0;
          wptr_q       <= '0;
          o_frame_done <= 1'b1;
        end else begin
          state_q <= (row_nx >= KM1_R) ? STREAM : FILL;
          col_q   <= col_nx;
          row_q   <= row_nx;
          wptr_q  <= wptr_nx;
        end
        if (win_ok) begin
          o_valid  <= 1'b1;
          o_window <= win_flat;
          o_row    <= 16'(pr) - 16'(HALF);
          o_col    <= 16'(pc) - 16'(HALF);
        end
      end
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
module tb_line_window_gen;

  localparam int DW = 12;
  localparam int RL = 8;
  localparam int NR = 6;
  localparam int K  = 3;
  localparam int WW = K * K * DW;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_sof;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic [WW-1:0] o_window;
  logic [15:0]   o_row;
  logic [15:0]   o_col;
  logic          o_frame_done;

  int checks = 0;
  int errors = 0;
  int nwin   = 0;
  logic [WW-1:0] last_win;

  line_window_gen #(.DW(DW), .RL(RL), .NROWS(NR), .K(K)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_sof(i_sof), .i_valid(i_valid),
    .i_data(i_data), .o_valid(o_valid), .o_window(o_window), .o_row(o_row),
    .o_col(o_col), .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Window of pixels ending at (r,c), value = row*16+col+off.
  function automatic logic [WW-1:0] exp_win(input int r, input int c, input logic [DW-1:0] off);
    logic [WW-1:0] w;
    w = '0;
    for (int wr = 0; wr < K; wr++)
      for (int wc = 0; wc < K; wc++)
        w[(wr*K+wc)*DW +: DW] = DW'((r-K+1+wr)*16 + (c-K+1+wc)) + off;
    return w;
  endfunction

  task automatic px(input logic sof, input int r, input int c, input logic [DW-1:0] off);
    logic ev;
    i_valid = 1'b1;
    i_sof   = sof;
    i_data  = DW'(r*16 + c) + off;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    ev = (r >= K-1) && (c >= K-1);
    chk($sformatf("valid(%0d,%0d)", r, c), 128'(o_valid), 128'(ev));
    chk($sformatf("fdone(%0d,%0d)", r, c), 128'(o_frame_done), 128'(r == NR-1 && c == RL-1));
    if (ev) begin
      last_win = exp_win(r, c, off);
      nwin++;
      chk($sformatf("win(%0d,%0d)", r, c), 128'(o_window), 128'(last_win));
      chk($sformatf("row(%0d,%0d)", r, c), 128'(o_row), 128'(r - 1));
      chk($sformatf("col(%0d,%0d)", r, c), 128'(o_col), 128'(c - 1));
    end else begin
      chk($sformatf("hold(%0d,%0d)", r, c), 128'(o_window), 128'(last_win));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
      chk("gap_valid", 128'(o_valid), 128'(0));
      chk("gap_fdone", 128'(o_frame_done), 128'(0));
      chk("gap_hold", 128'(o_window), 128'(last_win));
    end
  endtask

  // Pixel strobes without i_sof while the generator is idle must be dropped.
  task automatic drop(input int n);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      i_sof   = 1'b0;
      i_data  = DW'(12'h7A0 + i);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      chk("drop_valid", 128'(o_valid), 128'(0));
      chk("drop_fdone", 128'(o_frame_done), 128'(0));
    end
  endtask

  task automatic frame(input logic gaps, input logic [DW-1:0] off);
    nwin = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < RL; c++) begin
        px(r == 0 && c == 0, r, c, off);
        if (gaps) idle($urandom_range(0, 2));
      end
    chk("nwin", 128'(nwin), 128'((NR-K+1)*(RL-K+1)));
    idle(1);
  endtask

  initial begin
    i_rstn = 1'b0; i_sof = 1'b0; i_valid = 1'b0; i_data = '0;
    last_win = '0;

    // 1: reset with activity on the inputs
    for (int i = 0; i < 3; i++) begin
      i_valid = ~i_valid;
      i_sof   = i_valid;
      i_data  = DW'(i + 1);
      @(posedge i_clk); #1;
      chk("rst_valid", 128'(o_valid), 128'(0));
      chk("rst_win", 128'(o_window), 128'(0));
      chk("rst_fdone", 128'(o_frame_done), 128'(0));
      chk("rst_row", 128'(o_row), 128'(0));
    end
    i_valid = 1'b0; i_sof = 1'b0;
    i_rstn  = 1'b1;
    idle(2);

    // First window checked against the hand-computed word
    chk("first_win_const", 128'(exp_win(2, 2, '0)),
        128'(108'h022_021_020_012_011_010_002_001_000));

    // 2 + 4: continuous frame (covers row boundaries) and frame-done pulse
    frame(1'b0, '0);
    // 6: strobes without sof after frame end are ignored
    drop(4);

    // 3: same frame with random gaps
    frame(1'b1, '0);

    // 5: resync at (3,4); aborted frame carries distinct pixel values
    nwin = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < RL; c++)
        if (r < 3 || (r == 3 && c < 4)) px(r == 0 && c == 0, r, c, 12'h800);
    chk("abort_nwin", 128'(nwin), 128'(8));
    frame(1'b0, '0);

    // Mid-frame synchronous reset returns to idle
    nwin = 0;
    for (int c = 0; c < RL; c++) px(c == 0, 0, c, '0);
    for (int c = 0; c < RL; c++) px(1'b0, 1, c, '0);
    for (int c = 0; c < 4; c++)  px(1'b0, 2, c, '0);
    i_rstn = 1'b0;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    last_win = '0;
    chk("mrst_valid", 128'(o_valid), 128'(0));
    chk("mrst_win", 128'(o_window), 128'(0));
    drop(3);

    // Recovery after reset
    frame(1'b1, 12'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
